rib2sdr_bridge: RTL

RIB2SDR_BRIDGE -- requirements
Module: rib2sdr_bridge

---
 rtl/rib2sdr_bridge.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rib2sdr_bridge.sv
// RIB slave to SDRAM controller bridge.
// Writes are posted into a small FIFO and answered on the next cycle. Reads
// wait for that FIFO to drain, so a read always sees every earlier write.
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high (req/gnt, rsp/rdy, and app_*_en/(~busy & init_done)). Once raised, a
// valid and its payload stay stable until that transfer happens.
module rib2sdr_bridge #(
  parameter int DW         = 32,
  parameter int SDR_AW     = 21,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [31:0]                 i_ribs_addr,
  input  logic                        i_ribs_wrcs,
  input  logic [DW/8-1:0]             i_ribs_mask,
  input  logic [DW-1:0]               i_ribs_wdata,
  input  logic                        i_ribs_req,
  output logic                        o_ribs_gnt,
  output logic                        o_ribs_rsp,
  input  logic                        i_ribs_rdy,
  output logic [DW-1:0]               o_ribs_rdata,
  input  logic                        i_sdr_init_done,
  input  logic                        i_sdr_busy,
  output logic                        o_app_wr_en,
  output logic [SDR_AW-1:0]           o_app_wr_addr,
  output logic [DW/8-1:0]             o_app_wr_dm,
  output logic [DW-1:0]               o_app_wr_din,
  output logic                        o_app_rd_en,
  output logic [SDR_AW-1:0]           o_app_rd_addr,
  input  logic                        i_sdr_rd_vld,
  input  logic [DW-1:0]               i_sdr_rd_data,
  output logic [$clog2(WBUF_DEPTH):0] o_wbuf_level,
  output logic [1:0]                  o_dbg_state
);

  localparam int MW = DW / 8;
  localparam int BL = $clog2(MW);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_WAIT = 2'd2,
    RSP     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              wr_rsp_q;
  logic [SDR_AW-1:0] rd_addr_q;
  logic [DW-1:0]     rdata_q;

  logic [SDR_AW-1:0] wb_addr [WBUF_DEPTH];
  logic [MW-1:0]     wb_mask [WBUF_DEPTH];
  logic [DW-1:0]     wb_data [WBUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;

  logic              full, empty, push, pop, rd_acc, rd_start;
  logic [SDR_AW-1:0] word_addr;
  logic              unused_addr;

  // Only the word-address field of the byte address reaches the controller.
  assign word_addr   = i_ribs_addr[BL+SDR_AW-1:BL];
  assign unused_addr = ^{i_ribs_addr[31:BL+SDR_AW], i_ribs_addr[BL-1:0]};

  assign full  = (level_q == LW'(WBUF_DEPTH));
  assign empty = (level_q == '0);

  // Grant uses the registered full flag, so a full buffer never pushes and
  // pops in the same cycle; reads additionally wait for an empty buffer.
  assign o_ribs_gnt = i_ribs_req & ~i_rst & (state_q == IDLE) & i_sdr_init_done &
                      (~o_ribs_rsp | i_ribs_rdy) &
                      (i_ribs_wrcs ? ~full : empty);

  assign push     = o_ribs_gnt & i_ribs_wrcs;
  assign rd_start = o_ribs_gnt & ~i_ribs_wrcs;

  assign o_app_wr_en   = ~empty & (state_q != RD_CMD);
  assign o_app_wr_addr = wb_addr[rd_ptr_q];
  assign o_app_wr_dm   = wb_mask[rd_ptr_q];
  assign o_app_wr_din  = wb_data[rd_ptr_q];
  assign pop           = o_app_wr_en & ~i_sdr_busy & i_sdr_init_done;

  assign o_app_rd_en   = (state_q == RD_CMD);
  assign o_app_rd_addr = rd_addr_q;
  assign rd_acc        = o_app_rd_en & ~i_sdr_busy & i_sdr_init_done;

  assign o_ribs_rsp   = wr_rsp_q | (state_q == RSP);
  assign o_ribs_rdata = rdata_q;
  assign o_wbuf_level = level_q;
  assign o_dbg_state  = state_q;

  // Read-path next state; read data returning outside RD_WAIT is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_start)      state_d = RD_CMD;
      RD_CMD:  if (rd_acc)        state_d = RD_WAIT;
      RD_WAIT: if (i_sdr_rd_vld)  state_d = RSP;
      RSP:     if (i_ribs_rdy)    state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FSM register, read address/data capture and posted-write response flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wr_rsp_q  <= 1'b0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rd_start) rd_addr_q <= word_addr;
      if (state_q == RD_WAIT && i_sdr_rd_vld) rdata_q <= i_sdr_rd_data;
      if (push)            wr_rsp_q <= 1'b1;
      else if (i_ribs_rdy) wr_rsp_q <= 1'b0;
    end
  end

  // Write-buffer pointers and occupancy; push and pop together keep level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Write-buffer storage; contents need no reset because level gates use.
  always_ff @(posedge i_clk) begin
    if (push) begin
      wb_addr[wr_ptr_q] <= word_addr;
      wb_mask[wr_ptr_q] <= i_ribs_mask;
      wb_data[wr_ptr_q] <= i_ribs_wdata;
    end
  end

endmodule
